sram_1rw_param: RTL

Parametrised, synthesizable single-port (1RW) SRAM model. Successor to the fixed 32x1024 macro model, adding:
- generic width and depth;
- per-byte write mask;
- selectable read latency (1 or 2);
- a read-valid strobe;
- a post-reset clear sequencer that walks the whole array.

It sits wherever a core or DMA engine needs local scratch or instruction memory, before a hardened macro is available.

---
 rtl/sram_pkg.sv | 17 +
 rtl/sram_clear_fsm.sv | 77 +++++++
 rtl/sram_1rw_param.sv | 101 ++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared types and elaboration helpers for the parametrised 1RW SRAM model.
package sram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } clear_state_t;

   function automatic int byte_count(input int data_width);
      return data_width / 8;
   endfunction

   function automatic bit latency_ok(input int read_latency);
      return (read_latency == 1) || (read_latency == 2);
   endfunction

endpackage

// File: rtl/sram_clear_fsm.sv
// Post-reset clear sequencer: walks the array writing INIT_VALUE, then hands the
// array port to the user. Also flags accesses dropped while the clear runs.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   CLEAR | writing INIT_VALUE to clr_addr, user accesses dropped
//   READY | user port drives the array
module sram_clear_fsm
   import sram_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 10,
   parameter int                    INIT_CLEAR = 1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                              clk0,
   input  logic                              rst0,
   input  logic                              csb0,
   input  logic                              web0,
   input  logic [byte_count(DATA_WIDTH)-1:0] wmask0,
   input  logic [ADDR_WIDTH-1:0]             addr0,
   input  logic [DATA_WIDTH-1:0]             din0,
   output logic [byte_count(DATA_WIDTH)-1:0] arr_wen,
   output logic                              arr_ren,
   output logic [ADDR_WIDTH-1:0]             arr_addr,
   output logic [DATA_WIDTH-1:0]             arr_wdata,
   output logic                              init_busy0,
   output logic                              drop0
);

   localparam clear_state_t          RESET_STATE = (INIT_CLEAR != 0) ? CLEAR : READY;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = '1;

   clear_state_t          state, state_nxt;
   logic [ADDR_WIDTH-1:0] clr_addr, clr_addr_nxt;

   always_ff @(posedge clk0 or posedge rst0) begin
      if (rst0) begin
         state    <= RESET_STATE;
         clr_addr <= '0;
         drop0    <= 1'b0;
      end else begin
         state    <= state_nxt;
         clr_addr <= clr_addr_nxt;
         drop0    <= (state == CLEAR) && !csb0;
      end
   end

   always_comb begin
      state_nxt    = state;
      clr_addr_nxt = clr_addr;
      arr_wen      = '0;
      arr_ren      = 1'b0;
      arr_addr     = addr0;
      arr_wdata    = din0;
      case (state)
         CLEAR: begin
            arr_wen   = '1;
            arr_addr  = clr_addr;
            arr_wdata = INIT_VALUE;
            // Hold the counter at the last word so it never wraps.
            if (clr_addr == LAST_ADDR) state_nxt = READY;
            else clr_addr_nxt = clr_addr + 1'b1;
         end
         READY: begin
            if (!csb0) begin
               if (!web0) arr_wen = wmask0;
               else       arr_ren = 1'b1;
            end
         end
         default: state_nxt = RESET_STATE;
      endcase
   end

   assign init_busy0 = (state == CLEAR);

endmodule

// File: rtl/sram_1rw_param.sv
// Parametrised single-port SRAM model with byte mask, 1/2-cycle read latency,
// read-valid strobe and post-reset clear.
module sram_1rw_param
   import sram_pkg::*;
#(
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    ADDR_WIDTH   = 10,
   parameter int                    READ_LATENCY = 1,
   parameter int                    INIT_CLEAR   = 1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
   input  logic                              clk0,
   input  logic                              rst0,
   input  logic                              csb0,
   input  logic                              web0,
   input  logic [byte_count(DATA_WIDTH)-1:0] wmask0,
   input  logic [ADDR_WIDTH-1:0]             addr0,
   input  logic [DATA_WIDTH-1:0]             din0,
   output logic [DATA_WIDTH-1:0]             dout0,
   output logic                              dout_valid0,
   output logic                              init_busy0,
   output logic                              drop0
);

   localparam int NB    = byte_count(DATA_WIDTH);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   if (DATA_WIDTH % 8 != 0) begin : g_bad_width
      $error("sram_1rw_param: DATA_WIDTH must be a multiple of 8");
   end
   if (!latency_ok(READ_LATENCY)) begin : g_bad_latency
      $error("sram_1rw_param: READ_LATENCY must be 1 or 2");
   end

   logic [NB-1:0]         arr_wen;
   logic                  arr_ren;
   logic [ADDR_WIDTH-1:0] arr_addr;
   logic [DATA_WIDTH-1:0] arr_wdata;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   sram_clear_fsm #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .INIT_CLEAR (INIT_CLEAR),
      .INIT_VALUE (INIT_VALUE)
   ) u_clear_fsm (
      .clk0       (clk0),
      .rst0       (rst0),
      .csb0       (csb0),
      .web0       (web0),
      .wmask0     (wmask0),
      .addr0      (addr0),
      .din0       (din0),
      .arr_wen    (arr_wen),
      .arr_ren    (arr_ren),
      .arr_addr   (arr_addr),
      .arr_wdata  (arr_wdata),
      .init_busy0 (init_busy0),
      .drop0      (drop0)
   );

   // Array contents survive reset; only a clear sequence overwrites them.
   always_ff @(posedge clk0) begin
      for (int i = 0; i < NB; i++) begin
         if (arr_wen[i]) mem[arr_addr][8*i +: 8] <= arr_wdata[8*i +: 8];
      end
   end

   assign rd_word = mem[arr_addr];

   if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] s1_data;
      logic                  s1_valid;

      always_ff @(posedge clk0 or posedge rst0) begin
         if (rst0) begin
            s1_data     <= '0;
            s1_valid    <= 1'b0;
            dout0       <= '0;
            dout_valid0 <= 1'b0;
         end else begin
            s1_valid    <= arr_ren;
            if (arr_ren) s1_data <= rd_word;
            dout_valid0 <= s1_valid;
            if (s1_valid) dout0 <= s1_data;
         end
      end
   end else begin : g_lat1
      always_ff @(posedge clk0 or posedge rst0) begin
         if (rst0) begin
            dout0       <= '0;
            dout_valid0 <= 1'b0;
         end else begin
            dout_valid0 <= arr_ren;
            if (arr_ren) dout0 <= rd_word;
         end
      end
   end

endmodule
